// File: rtl/sprite_draw_engine_pkg.sv
// Shared constants and encodings for the sprite drawing blocks.
package sprite_draw_engine_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int COLOUR_W = 9;
  localparam logic [COLOUR_W-1:0] TRANSPARENT = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    MODE_BG   = 1'b0,
    MODE_CHAR = 1'b1
  } mode_t;

endpackage

// File: rtl/sprite_scan_counter.sv
// Column/row raster counter over a sprite window; column runs fastest.
module sprite_scan_counter #(
  parameter int SPRITE_W = 8,
  parameter int SPRITE_H = 8,
  localparam int COL_W = $clog2(SPRITE_W),
  localparam int ROW_W = $clog2(SPRITE_H)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clear_i,
  input  logic             enable_i,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic             last_o
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(SPRITE_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SPRITE_H - 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  // Row wraps to zero naturally because both dimensions are powers of two.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
    end else if (enable_i) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign last_o = (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

// File: rtl/sprite_draw_engine.sv
// Draw-handshake responder: scans a sprite window from the background or
// character ROM and drives the VGA adapter's plot interface.
module sprite_draw_engine
  import sprite_draw_engine_pkg::*;
#(
  parameter int SPRITE_W = 8,
  parameter int SPRITE_H = 8,
  localparam int COL_W  = $clog2(SPRITE_W),
  localparam int ROW_W  = $clog2(SPRITE_H),
  localparam int ADDR_W = COL_W + ROW_W
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                drawBG,
  input  logic                drawChar,
  input  logic [8:0]          xCoordinate,
  input  logic [7:0]          yCoordinate,
  output logic [16:0]         bgAddr,
  input  logic [COLOUR_W-1:0] bgData,
  output logic [ADDR_W-1:0]   charAddr,
  input  logic [COLOUR_W-1:0] charData,
  output logic                plot,
  output logic [8:0]          vgaX,
  output logic [7:0]          vgaY,
  output logic [COLOUR_W-1:0] colour,
  output logic                doneBG,
  output logic                doneChar
);

  state_t state_q, state_d;
  mode_t  mode_q, mode_d;
  logic [8:0] baseX_q, baseX_d;
  logic [7:0] baseY_q, baseY_d;
  logic doneBG_q, doneBG_d;
  logic doneChar_q, doneChar_d;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic lastPix;
  logic issue;
  logic [9:0] xSum;
  logic [8:0] ySum;
  logic [16:0] bgAddrCalc;

  logic valid1_q;
  logic [9:0] x1_q;
  logic [8:0] y1_q;
  logic plot_q, plot_d;
  logic [8:0] vgaX_q;
  logic [7:0] vgaY_q;
  logic [COLOUR_W-1:0] colour_q, pixelColour;

  assign issue = (state_q == SCAN);

  sprite_scan_counter #(
    .SPRITE_W(SPRITE_W),
    .SPRITE_H(SPRITE_H)
  ) u_scan (
    .clock   (clock),
    .resetn  (resetn),
    .clear_i (state_q == IDLE),
    .enable_i(issue),
    .col_o   (col),
    .row_o   (row),
    .last_o  (lastPix)
  );

  // Sums keep their carry so a wrap past 511/255 is seen as off-screen.
  assign xSum = {1'b0, baseX_q} + {{(10 - COL_W){1'b0}}, col};
  assign ySum = {1'b0, baseY_q} + {{(9 - ROW_W){1'b0}}, row};
  assign bgAddrCalc = {1'b0, ySum[7:0], 8'b0} + {3'b0, ySum[7:0], 6'b0}
                    + {8'b0, xSum[8:0]};

  assign bgAddr   = issue ? bgAddrCalc : '0;
  assign charAddr = issue ? {row, col} : '0;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    baseX_d    = baseX_q;
    baseY_d    = baseY_q;
    doneBG_d   = 1'b0;
    doneChar_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (drawBG || drawChar) begin
          baseX_d = xCoordinate;
          baseY_d = yCoordinate;
          mode_d  = drawBG ? MODE_BG : MODE_CHAR;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (lastPix) state_d = FLUSH;
      end
      FLUSH: state_d = DONE;
      DONE: begin
        // Done is shown for at least one cycle even if the request already fell.
        doneBG_d   = (mode_q == MODE_BG);
        doneChar_d = (mode_q == MODE_CHAR);
        if ((doneBG_q || doneChar_q) &&
            !((mode_q == MODE_BG) ? drawBG : drawChar)) begin
          doneBG_d   = 1'b0;
          doneChar_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= IDLE;
      mode_q     <= MODE_BG;
      baseX_q    <= '0;
      baseY_q    <= '0;
      doneBG_q   <= 1'b0;
      doneChar_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      baseX_q    <= baseX_d;
      baseY_q    <= baseY_d;
      doneBG_q   <= doneBG_d;
      doneChar_q <= doneChar_d;
    end
  end

  assign pixelColour = (mode_q == MODE_CHAR) ? charData : bgData;
  assign plot_d = valid1_q && (x1_q < 10'(SCREEN_W)) && (y1_q < 9'(SCREEN_H))
                && !((mode_q == MODE_CHAR) && (charData == TRANSPARENT));

  // Stage 1 lines coordinates up with ROM data; stage 2 drives the VGA port.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      valid1_q <= 1'b0;
      x1_q     <= '0;
      y1_q     <= '0;
      plot_q   <= 1'b0;
      vgaX_q   <= '0;
      vgaY_q   <= '0;
      colour_q <= '0;
    end else begin
      valid1_q <= issue;
      x1_q     <= xSum;
      y1_q     <= ySum;
      plot_q   <= plot_d;
      vgaX_q   <= x1_q[8:0];
      vgaY_q   <= y1_q[7:0];
      colour_q <= pixelColour;
    end
  end

  assign plot     = plot_q;
  assign vgaX     = vgaX_q;
  assign vgaY     = vgaY_q;
  assign colour   = colour_q;
  assign doneBG   = doneBG_q;
  assign doneChar = doneChar_q;

endmodule

// File: doc/sprite_draw_engine.md
Name: sprite_draw_engine

Overview:
- Responder side of the movement FSM's draw handshake.
- Accepts a level request, drawBG or drawChar, plus a sprite top-left coordinate, then scans a SPRITE_W x SPRITE_H window.
- Background requests restore pixels from the background ROM. Character requests plot the character ROM, skipping the transparent key colour.
- Drives the VGA adapter's plot/x/y/colour inputs and answers with doneBG/doneChar.

Parameters:
SPRITE_W, 8, sprite width in pixels (power of 2)
SPRITE_H, 8, sprite height in pixels (power of 2)
COLOUR_W, 9, colour bits per pixel
TRANSPARENT, 9'h1FF, character colour that is never plotted
SCREEN_W, 320, screen width in pixels
SCREEN_H, 240, screen height in pixels

Ports:
clock  in  1  system clock
resetn  in  1  synchronous, active-low reset
drawBG  in  1  level request: restore background under sprite window
drawChar  in  1  level request: draw character sprite
xCoordinate  in  9  sprite top-left X, sampled at request acceptance
yCoordinate  in  8  sprite top-left Y, sampled at request acceptance
bgAddr  out  17  background ROM address, y*320+x
bgData  in  COLOUR_W  background ROM data, 1-cycle read latency
charAddr  out  log2(W*H)  character ROM address, row*SPRITE_W+col
charData  in  COLOUR_W  character ROM data, 1-cycle read latency
plot  out  1  VGA write enable
vgaX  out  9  VGA pixel X
vgaY  out  8  VGA pixel Y
colour  out  COLOUR_W  VGA pixel colour
doneBG  out  1  background request complete
doneChar  out  1  character request complete

Behaviour:
- Reset (clock, resetn synchronous active-low) → state IDLE. plot, doneBG, doneChar, vgaX, vgaY, colour, bgAddr and charAddr are all 0. Counters and latched base are 0.
- IDLE:
  - If drawBG=1: latch base X/Y, set mode=BG, go to SCAN.
  - Else if drawChar=1: latch base X/Y, set mode=CHAR, go to SCAN.
  - drawBG has priority when both are high.
- SCAN: one address per cycle, col fastest, col 0..W-1 then row 0..H-1.
  - bgAddr = (baseY+row)*320 + (baseX+col), computed as (y<<8)+(y<<6)+x in 17 bits.
  - charAddr = row*SPRITE_W+col.
  - After issuing the last address (col=W-1, row=H-1), go to FLUSH.
- Output stage, registered, one cycle behind address issue:
  - vgaX/vgaY = delayed base+col / base+row.
  - colour = selected ROM data.
  - plot = delayed valid AND in-bounds (x<SCREEN_W, y<SCREEN_H) AND NOT (mode=CHAR AND charData==TRANSPARENT).
  - Out-of-bounds or transparent pixels still consume their cycle.
- FLUSH: one cycle to emit the last pixel, then go to DONE.
- DONE:
  - Assert doneBG (mode BG) or doneChar (mode CHAR).
  - Hold it while the matching request stays high.
  - When the request drops, deassert done next cycle and return to IDLE.
  - A request still high in DONE never restarts a scan (four-phase handshake).
- Latency: request high in IDLE → first plot 2 cycles later. Done rises W*H+2 cycles after acceptance (66 for 8x8).
- Coordinate arithmetic: 9-bit X and 8-bit Y adds. A sum ≥ SCREEN_W/H, including a wrap past 511/255, is treated as out-of-bounds. Compute in-bounds from the carry-extended sum.
- Request drop mid-SCAN is ignored; the scan completes, and DONE then sees the request low and returns to IDLE after one done cycle.
- xCoordinate/yCoordinate changes after acceptance have no effect.
- Reset mid-operation aborts immediately: plot=0, done=0, IDLE. No residual plot is issued.

Decomposition:
- Shared package holds:
  - screen constants SCREEN_W/SCREEN_H
  - COLOUR_W and TRANSPARENT key
  - state encoding IDLE/SCAN/FLUSH/DONE
  - mode encoding BG/CHAR
- One natural sub-module, sprite_scan_counter: a col/row counter with clear, enable and a last flag. It is reused by future sprite blocks.
- FSM, address generation and output pipeline stay in the top module.

Test Plan:
- Draw BG at (95,221), 8x8, bgData=address low bits → 64 plots at x 95..102, y 221..228. First plot has bgAddr=221*320+95=70815. doneBG high at cycle 66; it clears one cycle after drawBG drops.
- Draw character at (126,68) with charData=5 except address 9 = 9'h1FF → 63 plots. There is no plot at (127,69). doneChar is held until drawChar falls.
- Clipping: draw BG at (316,236) → plots only for x 316..319, y 236..239, giving 16 plots. Done still at cycle 66.
- drawBG and drawChar both high in IDLE → BG mode; only doneBG asserts. Holding drawBG high through DONE for 10 cycles produces no second scan.
- Assert resetn=0 at pixel 30 of a scan → next cycle plot=0, done=0, state IDLE. A new drawChar afterwards completes normally with 64 pixels.
- Change xCoordinate from 95 to 200 mid-scan → all plots remain at x 95..102.
